// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state codes, button bit positions and the button decoder
// used by the fighter FSM and by any opponent/AI logic that needs the same mapping.
package fighter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FWD       = 4'd1,
        ST_BACK      = 4'd2,
        ST_BA_START  = 4'd3,
        ST_BA_ACT    = 4'd4,
        ST_BA_REC    = 4'd5,
        ST_DA_START  = 4'd6,
        ST_DA_ACT    = 4'd7,
        ST_DA_REC    = 4'd8,
        ST_HIT_STUN  = 4'd9,
        ST_BLK_STUN  = 4'd10,
        ST_DEAD      = 4'd11
    } state_t;

    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ATTACK = 0;

    // Priority order matters: a left+right chord with attack is a basic attack, not directional.
    function automatic state_t decode_buttons(input logic [2:0] buttons);
        logic l, r, a;
        l = buttons[BTN_LEFT];
        r = buttons[BTN_RIGHT];
        a = buttons[BTN_ATTACK];
        if (a && l && r)      return ST_BA_START;
        else if (a && (l ^ r)) return ST_DA_START;
        else if (l && r)      return ST_IDLE;
        else if (a)           return ST_BA_START;
        else if (l)           return ST_BACK;
        else if (r)           return ST_FWD;
        else                  return ST_IDLE;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stock_meter.sv
// Saturating up/down counter with a registered thermometer display (bit i set iff count > i).
// Used for both the lives and the block meter.
module stock_meter
    import fighter_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = cnt_width(MAX)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           inc,
    input  logic           dec,
    output logic [W-1:0]   count,
    output logic [MAX-1:0] led
);

    logic [MAX-1:0] therm;

    for (genvar i = 0; i < MAX; i++) begin : g_therm
        assign therm[i] = (count > W'(i));
    end

    // The display trails the count by one clock because it is built from the registered count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= W'(MAX);
            led   <= '1;
        end else begin
            if (dec && count != '0)
                count <= count - W'(1);
            else if (inc && count != W'(MAX))
                count <= count + W'(1);
            led <= therm;
        end
    end

endmodule

// File: rtl/fighter_fsm_param.sv
// Per-player fighter state machine: button decode, timed attack phases, hit/block handling,
// post-hit invulnerability, block regeneration and a sticky DEAD state, all advanced on frame_tick.
module fighter_fsm_param
    import fighter_pkg::*;
#(
    parameter int BASIC_START = 5,
    parameter int BASIC_ACTIVE = 2,
    parameter int BASIC_REC   = 16,
    parameter int DIR_START   = 4,
    parameter int DIR_ACTIVE  = 3,
    parameter int DIR_REC     = 15,
    parameter int HSTUN_BASIC = 15,
    parameter int HSTUN_DIR   = 14,
    parameter int BSTUN_BASIC = 13,
    parameter int BSTUN_DIR   = 12,
    parameter int MAX_LIVES   = 3,
    parameter int MAX_BLOCKS  = 3,
    parameter int INVULN      = 8,
    parameter int REGEN       = 60
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    input  logic [2:0]            buttons,
    input  logic                  hitscan,
    input  logic [3:0]            opp_state,
    output logic [3:0]            p_state,
    output logic [MAX_LIVES-1:0]  lives_led,
    output logic [MAX_BLOCKS-1:0] blocks_led,
    output logic                  died,
    output logic                  hit_pulse
);

    localparam int MAX_DUR = max_int(max_int(max_int(BASIC_START, BASIC_ACTIVE), max_int(BASIC_REC, DIR_START)),
                             max_int(max_int(max_int(DIR_ACTIVE, DIR_REC), max_int(HSTUN_BASIC, HSTUN_DIR)),
                                     max_int(BSTUN_BASIC, BSTUN_DIR)));
    localparam int CW = cnt_width(MAX_DUR);
    localparam int LW = cnt_width(MAX_LIVES);
    localparam int BW = cnt_width(MAX_BLOCKS);
    localparam int IW = cnt_width(INVULN);
    localparam int RW = cnt_width(REGEN);

    state_t          state;
    state_t          decoded;
    logic [CW-1:0]   cnt, stun_len, dur;
    logic [IW-1:0]   invuln;
    logic [RW-1:0]   regen_cnt;
    logic [LW-1:0]   lives;
    logic [BW-1:0]   blocks;
    logic            neutral, hit, block_hit, dwell_done, blocks_full, regen_fire, opp_dir;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dur = CW'(1);
        case (state)
            ST_BA_START: dur = CW'(BASIC_START);
            ST_BA_ACT:   dur = CW'(BASIC_ACTIVE);
            ST_BA_REC:   dur = CW'(BASIC_REC);
            ST_DA_START: dur = CW'(DIR_START);
            ST_DA_ACT:   dur = CW'(DIR_ACTIVE);
            ST_DA_REC:   dur = CW'(DIR_REC);
            ST_HIT_STUN, ST_BLK_STUN: dur = stun_len;
            default:     dur = CW'(1);
        endcase
    end

    assign decoded     = decode_buttons(buttons);
    assign dwell_done  = (cnt == dur - CW'(1));
    assign neutral     = state inside {ST_IDLE, ST_FWD, ST_BACK};
    assign opp_dir     = (opp_state == 4'(ST_DA_ACT));
    assign hit         = frame_tick && hitscan && (invuln == '0)
                         && !(state inside {ST_HIT_STUN, ST_BLK_STUN, ST_DEAD});
    assign block_hit   = hit && (state == ST_BACK) && (blocks != '0);
    assign blocks_full = (blocks == BW'(MAX_BLOCKS));
    // A hit on the same tick suppresses regeneration.
    assign regen_fire  = frame_tick && !hit && neutral && !blocks_full && (REGEN != 0)
                         && (regen_cnt == RW'(REGEN - 1));

    stock_meter #(.MAX(MAX_LIVES)) u_lives (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (1'b0),
        .dec     (hit && !block_hit),
        .count   (lives),
        .led     (lives_led)
    );

    stock_meter #(.MAX(MAX_BLOCKS)) u_blocks (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (regen_fire),
        .dec     (block_hit),
        .count   (blocks),
        .led     (blocks_led)
    );

    // NOTE: state registers use non-blocking assignments; later assignments in the block override defaults.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stun_len  <= '0;
            invuln    <= '0;
            died      <= 1'b0;
            hit_pulse <= 1'b0;
        end else if (!frame_tick) begin
            hit_pulse <= 1'b0;
        end else begin
            hit_pulse <= hit;
            cnt       <= cnt + CW'(1);
            if (invuln != '0)
                invuln <= invuln - IW'(1);

            if (hit) begin
                cnt <= '0;
                if (block_hit) begin
                    state    <= ST_BLK_STUN;
                    stun_len <= opp_dir ? CW'(BSTUN_DIR) : CW'(BSTUN_BASIC);
                end else if (lives <= LW'(1)) begin
                    state <= ST_DEAD;
                    died  <= 1'b1;
                end else begin
                    state    <= ST_HIT_STUN;
                    stun_len <= opp_dir ? CW'(HSTUN_DIR) : CW'(HSTUN_BASIC);
                end
            end else begin
                case (state)
                    ST_IDLE, ST_FWD, ST_BACK: begin
                        state <= decoded;
                        cnt   <= '0;
                    end
                    ST_BA_START: if (dwell_done) begin state <= ST_BA_ACT;   cnt <= '0; end
                    ST_BA_ACT:   if (dwell_done) begin state <= ST_BA_REC;   cnt <= '0; end
                    ST_DA_START: if (dwell_done) begin state <= ST_DA_ACT;   cnt <= '0; end
                    ST_DA_ACT:   if (dwell_done) begin state <= ST_DA_REC;   cnt <= '0; end
                    ST_BA_REC, ST_DA_REC, ST_BLK_STUN:
                        if (dwell_done) begin state <= decoded; cnt <= '0; end
                    ST_HIT_STUN:
                        if (dwell_done) begin
                            state  <= decoded;
                            cnt    <= '0;
                            invuln <= IW'(INVULN);
                        end
                    ST_DEAD: cnt <= '0;
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            regen_cnt <= '0;
        else if (frame_tick) begin
            if (hit || !neutral || blocks_full || regen_fire)
                regen_cnt <= '0;
            else
                regen_cnt <= regen_cnt + RW'(1);
        end
    end

    assign p_state = state;

endmodule

// File: tb/tb_fighter_fsm_param.sv
// Directed bench for fighter_fsm_param: expected state/pulse pushed per frame tick into a
// scoreboard queue and popped once the registered outputs settle.
module tb_fighter_fsm_param;
    import fighter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic [2:0] buttons;
    logic       hitscan;
    logic [3:0] opp_state;
    logic [3:0] p_state;
    logic [2:0] lives_led;
    logic [2:0] blocks_led;
    logic       died;
    logic       hit_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       pulse;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    localparam logic [2:0] B_NONE = 3'b000;
    localparam logic [2:0] B_ATK  = 3'b001;
    localparam logic [2:0] B_R    = 3'b010;
    localparam logic [2:0] B_L    = 3'b100;
    localparam logic [2:0] B_LR   = 3'b110;
    localparam logic [2:0] B_LA   = 3'b101;

    always #5 clk = ~clk;

    fighter_fsm_param dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .buttons    (buttons),
        .hitscan    (hitscan),
        .opp_state  (opp_state),
        .p_state    (p_state),
        .lives_led  (lives_led),
        .blocks_led (blocks_led),
        .died       (died),
        .hit_pulse  (hit_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One idle clock, then one frame_tick clock; outputs compared at the following negedge.
    task automatic step(input logic [2:0] b, input logic hs, input logic [3:0] opp,
                        input logic [3:0] es, input logic ep, input string tag);
        exp_t  e;
        string t;
        exp_q.push_back(exp_t'{st: es, pulse: ep});
        tag_q.push_back(tag);
        @(negedge clk);
        buttons = b; hitscan = hs; opp_state = opp; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_state"}, 32'(p_state), 32'(e.st));
        check({t, "_pulse"}, 32'(hit_pulse), 32'(e.pulse));
    endtask

    task automatic run(input int n, input logic [2:0] b, input logic hs, input logic [3:0] opp,
                       input logic [3:0] es, input string tag);
        for (int i = 0; i < n; i++)
            step(b, hs, opp, es, 1'b0, tag);
    endtask

    // One extra clock so the thermometer displays catch up, and the hit pulse must be gone.
    task automatic meters(input logic [2:0] el, input logic [2:0] eb, input logic ed, input string tag);
        @(negedge clk);
        check({tag, "_lives"},  32'(lives_led),  32'(el));
        check({tag, "_blocks"}, 32'(blocks_led), 32'(eb));
        check({tag, "_died"},   32'(died),       32'(ed));
        check({tag, "_pulse0"}, 32'(hit_pulse),  32'(0));
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0; frame_tick = 1'b1; buttons = B_ATK; hitscan = 1'b1; opp_state = 4'd7;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_state"},  32'(p_state),    32'(0));
        check({tag, "_lives"},  32'(lives_led),  32'(3'b111));
        check({tag, "_blocks"}, 32'(blocks_led), 32'(3'b111));
        check({tag, "_died"},   32'(died),       32'(0));
        check({tag, "_pulse"},  32'(hit_pulse),  32'(0));
        reset_n = 1'b1; frame_tick = 1'b0; buttons = B_NONE; hitscan = 1'b0; opp_state = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset_n = 1'b0; frame_tick = 1'b0; buttons = B_NONE; hitscan = 1'b0; opp_state = 4'd0;
        apply_reset("reset");

        step(B_R,  1'b0, 4'd0, 4'd1, 1'b0, "dec_fwd");
        step(B_L,  1'b0, 4'd0, 4'd2, 1'b0, "dec_back");
        step(B_LR, 1'b0, 4'd0, 4'd0, 1'b0, "dec_lr");

        // Single attack tap from IDLE: 3 x5, 4 x2, 5 x16, then IDLE.
        step(B_ATK, 1'b0, 4'd0, 4'd3, 1'b0, "ba_start");
        run(4,  B_NONE, 1'b0, 4'd0, 4'd3, "ba_start");
        run(2,  B_NONE, 1'b0, 4'd0, 4'd4, "ba_act");
        run(16, B_NONE, 1'b0, 4'd0, 4'd5, "ba_rec");
        step(B_NONE, 1'b0, 4'd0, 4'd0, 1'b0, "ba_exit");

        // Directional attack with left held: 6 x4, 7 x3, 8 x15, exit to BACK.
        run(4,  B_LA, 1'b0, 4'd0, 4'd6, "da_start");
        run(3,  B_LA, 1'b0, 4'd0, 4'd7, "da_act");
        run(15, B_L,  1'b0, 4'd0, 4'd8, "da_rec");
        step(B_L, 1'b0, 4'd0, 4'd2, 1'b0, "da_exit_back");

        // Block a directional attack from BACK: 12 ticks of block stun.
        step(B_L, 1'b1, 4'd7, 4'd10, 1'b1, "block_hit");
        meters(3'b111, 3'b011, 1'b0, "block_meter");
        run(11, B_L, 1'b1, 4'd7, 4'd10, "blk_stun");
        step(B_L, 1'b0, 4'd0, 4'd2, 1'b0, "blk_exit");

        // 59 neutral ticks, then a hit on the 60th: hit wins, no regeneration.
        run(59, B_NONE, 1'b0, 4'd0, 4'd0, "regen_wait");
        meters(3'b111, 3'b011, 1'b0, "regen_59");
        step(B_NONE, 1'b1, 4'd0, 4'd9, 1'b1, "hit_vs_regen");
        meters(3'b011, 3'b011, 1'b0, "hit1_meter");

        // Hitscan held through hit stun and the following invulnerability window.
        run(14, B_NONE, 1'b1, 4'd0, 4'd9, "hit_stun1");
        step(B_NONE, 1'b1, 4'd0, 4'd0, 1'b0, "hstun_exit");
        run(8, B_NONE, 1'b1, 4'd0, 4'd0, "invuln");
        step(B_NONE, 1'b1, 4'd0, 4'd9, 1'b1, "hit_after_invuln");
        meters(3'b001, 3'b011, 1'b0, "hit2_meter");

        // Recover, then regenerate one block on the 60th neutral tick.
        run(14, B_NONE, 1'b0, 4'd0, 4'd9, "hit_stun2");
        step(B_NONE, 1'b0, 4'd0, 4'd0, 1'b0, "hstun2_exit");
        run(59, B_NONE, 1'b0, 4'd0, 4'd0, "regen_run");
        meters(3'b001, 3'b011, 1'b0, "regen_pre");
        step(B_NONE, 1'b0, 4'd0, 4'd0, 1'b0, "regen_tick60");
        meters(3'b001, 3'b111, 1'b0, "regen_done");

        // Last life lost: DEAD is sticky and ignores buttons and hitscan.
        step(B_NONE, 1'b1, 4'd7, 4'd11, 1'b1, "kill");
        meters(3'b000, 3'b111, 1'b1, "dead_meter");
        run(3, B_ATK, 1'b1, 4'd7, 4'd11, "dead_sticky");

        apply_reset("reset_from_dead");

        // A hit during an attack phase aborts it.
        step(B_ATK, 1'b0, 4'd0, 4'd3, 1'b0, "abort_start");
        step(B_NONE, 1'b1, 4'd7, 4'd9, 1'b1, "abort_hit");
        meters(3'b011, 3'b111, 1'b0, "abort_meter");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
